// File: rtl/gaussian_accel_pkg.sv
// Shared constants for the 3x3 Gaussian convolution accelerator: register map,
// FSM state encoding and the power-on kernel (1-2-1 binomial, sums to 16).
// Pure declarations, no logic.
package gaussian_accel_pkg;

    localparam int unsigned NUM_TAPS    = 9;

    // Word addresses on the lightweight bus
    localparam int unsigned ADDR_RESULT = 0;
    localparam int unsigned ADDR_PIX0   = 1;
    localparam int unsigned ADDR_CTRL   = 10;
    localparam int unsigned ADDR_STATUS = 11;
    localparam int unsigned ADDR_COEF0  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        NORM = 2'd2
    } state_t;

    // Row-major default kernel loaded at reset
    localparam int unsigned DEFAULT_COEF [0:NUM_TAPS-1] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

endpackage

// File: rtl/gaussian_mac.sv
// Multiply-accumulate datapath: combinational pixel*coef product, registered accumulator,
// combinational round / right-shift / saturate of the accumulator onto result_o.
// Latency: one cycle per tap into the accumulator; no backpressure (driven by the owning FSM).
module gaussian_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4,
    parameter int ACC_W  = PIX_W + COEF_W + 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic [PIX_W-1:0]  result_o
);

    localparam logic [ACC_W:0]   HALF    = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    logic [PIX_W+COEF_W-1:0] prod;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W:0]          rounded;
    logic [ACC_W:0]          shifted;

    // Product of the current tap and the accumulator's next value
    always_comb begin
        prod  = (PIX_W+COEF_W)'(pix_i) * (PIX_W+COEF_W)'(coef_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Round half-up, normalise, clamp to the pixel range
    always_comb begin
        rounded  = {1'b0, acc_q} + HALF;
        shifted  = rounded >> SHIFT;
        result_o = (shifted > {{(ACC_W+1-PIX_W){1'b0}}, PIX_MAX}) ? PIX_MAX : shifted[PIX_W-1:0];
    end

endmodule

// File: rtl/gaussian_conv_accel.sv
// Memory-mapped 3x3 convolution slave: pixel/coefficient register file, bus decode, MAC sequencing FSM.
// Latency: RESULT/done 10 edges after start; reads return registered data one cycle after rd_en.
// No backpressure; writes to PIX/COEF/start while busy are dropped. Optional AUTO_START_EN: PIX[8] write starts a job.
module gaussian_conv_accel
    import gaussian_accel_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(ADDR_RESULT);
    localparam logic [ADDR_W-1:0] A_PIX0   = ADDR_W'(ADDR_PIX0);
    localparam logic [ADDR_W-1:0] A_PIX8   = ADDR_W'(ADDR_PIX0 + NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_COEF0  = ADDR_W'(ADDR_COEF0);
    localparam logic [ADDR_W-1:0] A_COEF8  = ADDR_W'(ADDR_COEF0 + NUM_TAPS - 1);
    localparam logic [3:0]        LAST_TAP = 4'(NUM_TAPS - 1);

    logic [PIX_W-1:0]  pix_q  [0:NUM_TAPS-1];
    logic [COEF_W-1:0] coef_q [0:NUM_TAPS-1];
    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PIX_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0] readdata_q, rdata_d;
    logic [PIX_W-1:0]  mac_result;

    logic              is_pix, is_coef, is_idle;
    logic [3:0]        pix_sel, coef_sel;
    logic              start_req, clear_req;
    logic              unused_wdata;

    assign is_idle      = (state_q == IDLE);
    assign is_pix       = (addr >= A_PIX0) && (addr <= A_PIX8);
    assign is_coef      = (addr >= A_COEF0) && (addr <= A_COEF8);
    assign pix_sel      = 4'(addr - A_PIX0);
    assign coef_sel     = 4'(addr - A_COEF0);
    assign clear_req    = wr_en && (addr == A_CTRL) && writedata[1];
    assign unused_wdata = ^writedata;

`ifdef AUTO_START_EN
    // Legacy flow: loading the last pixel kicks the job off
    assign start_req = wr_en && (((addr == A_CTRL) && writedata[0]) || (addr == A_PIX8));
`else
    assign start_req = wr_en && (addr == A_CTRL) && writedata[0];
`endif

    gaussian_mac #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (is_idle && start_req),
        .en_i     (state_q == MAC),
        .pix_i    (pix_q[idx_q]),
        .coef_i   (coef_q[idx_q]),
        .result_o (mac_result)
    );

    // Pixel and coefficient register file; frozen while a job is running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                pix_q[i]  <= '0;
                coef_q[i] <= COEF_W'(DEFAULT_COEF[i]);
            end
        end else if (wr_en && is_idle) begin
            if (is_pix)  pix_q[pix_sel]   <= writedata[PIX_W-1:0];
            if (is_coef) coef_q[coef_sel] <= writedata[COEF_W-1:0];
        end
    end

    // Job sequencing: IDLE -> MAC x9 -> NORM -> IDLE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = MAC;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (clear_req) begin
                    done_d  = 1'b0;
                end
            end
            MAC: begin
                if (idx_q == LAST_TAP) begin
                    state_d = NORM;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                end
            end
            NORM: begin
                result_d = mac_result;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Read decode from pre-edge register contents
    always_comb begin
        rdata_d = '0;
        if (addr == A_RESULT) begin
            rdata_d = DATA_W'(result_q);
        end else if (is_pix) begin
            rdata_d = DATA_W'(pix_q[pix_sel]);
        end else if (addr == A_STATUS) begin
            rdata_d = DATA_W'({done_q, busy_q});
        end else if (is_coef) begin
            rdata_d = DATA_W'(coef_q[coef_sel]);
        end
    end

    // Registered read port, holds when no read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = done_q;

endmodule

// File: tb/tb_gaussian_conv_accel.sv
module tb_gaussian_conv_accel;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_test = 0;
    int n_fail = 0;
    int cur_test = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        logic [4:0]  a;
        int          tag;
    } exp_t;

    exp_t sb[$];
    logic rd_seen;

    always #5 clk = ~clk;

    gaussian_conv_accel dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    // A read strobe accepted on a rising edge makes readdata valid for the following cycle
    always @(posedge clk or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= rd_en;
    end

    // Monitor: pop the expected value for every completed read and compare
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_seen) begin
            if (sb.size() == 0) begin
                n_test++;
                n_fail++;
                $display("FAIL unexpected_read got=%0d with empty scoreboard", readdata);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    n_test++;
                    if (readdata !== e.exp) begin
                        n_fail++;
                        $display("FAIL rd_t%0d_addr%0d got=%0d want=%0d", e.tag, e.a, readdata, e.exp);
                    end
                end
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; writedata = d; wr_en = 1'b1; rd_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        @(negedge clk);
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        sb.push_back('{1'b1, e, a, cur_test});
    endtask

    task automatic rd_nc(input logic [4:0] a);
        @(negedge clk);
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        sb.push_back('{1'b0, 32'd0, a, cur_test});
    endtask

    task automatic rdwr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        addr = a; writedata = d; rd_en = 1'b1; wr_en = 1'b1;
        sb.push_back('{1'b1, e, a, cur_test});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic load_pix(input int p [9]);
        for (int i = 0; i < 9; i++) wr(5'(1 + i), 32'(p[i]));
    endtask

    task automatic load_coef(input int c [9]);
        for (int i = 0; i < 9; i++) wr(5'(16 + i), 32'(c[i]));
    endtask

    // Poll STATUS until done is set, bounded
    task automatic poll_done();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            rd_nc(5'd11);
            idle();
            if (readdata[1]) found = 1'b1;
        end
        n_test++;
        if (!found) begin
            n_fail++;
            $display("FAIL poll_timeout_t%0d got=done0 want=done1", cur_test);
        end
    endtask

    task automatic run_expect(input logic [31:0] res);
        wr(5'd10, 32'd1);
        poll_done();
        rd(5'd0, res);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv [9];
        int cv [9];
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        reset = 1'b0;

        // Reset state and address map
        cur_test = 0;
        rd(5'd11, 32'd0);
        rd(5'd0, 32'd0);
        rd(5'd16, 32'd1);
        rd(5'd20, 32'd4);
        rd(5'd24, 32'd1);
        rd(5'd1, 32'd0);
        rd(5'd12, 32'd0);
        rd(5'd10, 32'd0);
        wr(5'd13, 32'd5);
        rd(5'd13, 32'd0);
        idle();

        // Test 1: PIX=1..9, default kernel, exact latency
        cur_test = 1;
        pv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_pix(pv);
        rdwr(5'd1, 32'd7, 32'd1);
        rd(5'd1, 32'd7);
        wr(5'd1, 32'd1);
        wr(5'd10, 32'd1);
        rd(5'd11, 32'd1);
        repeat (8) idle();
        rd(5'd11, 32'd1);
        rd(5'd11, 32'd2);
        rd(5'd0, 32'd5);
        idle();
        check("t1_irq", {31'd0, irq}, 32'd1);

        // Test 2: mixed pixels, start clears done, explicit clear
        cur_test = 2;
        pv = '{15, 51, 100, 20, 241, 95, 152, 75, 82};
        load_pix(pv);
        wr(5'd10, 32'd1);
        idle();
        check("t2_start_clears_done", {31'd0, irq}, 32'd0);
        poll_done();
        rd(5'd0, 32'd112);
        idle();
        check("t2_irq", {31'd0, irq}, 32'd1);
        wr(5'd10, 32'd2);
        idle();
        check("t2_clear_irq", {31'd0, irq}, 32'd0);
        rd(5'd11, 32'd0);
        idle();

        // Test 3: full-scale and zero images
        cur_test = 3;
        pv = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        load_pix(pv);
        run_expect(32'd255);
        pv = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_pix(pv);
        run_expect(32'd0);

        // Test 4: saturation with maximal kernel, kernel readback
        cur_test = 4;
        cv = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        load_coef(cv);
        pv = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        load_pix(pv);
        run_expect(32'd255);
        cv = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        load_coef(cv);
        for (int i = 0; i < 9; i++) rd(5'(16 + i), 32'(cv[i]));
        wr(5'd10, 32'd2);
        idle();

        // Test 6: writing PIX[8] alone starts a job only with AUTO_START_EN
        cur_test = 6;
        pv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_pix(pv);
        repeat (10) idle();
`ifdef AUTO_START_EN
        rd(5'd0, 32'd5);
        rd(5'd11, 32'd2);
`else
        rd(5'd0, 32'd255);
        rd(5'd11, 32'd0);
`endif
        idle();

        // Test 5: writes during a job are ignored, then reset mid-job
        cur_test = 5;
        wr(5'd10, 32'd1);
        repeat (3) idle();
        wr(5'd5, 32'd99);
        wr(5'd10, 32'd1);
        poll_done();
        rd(5'd0, 32'd5);
        rd(5'd5, 32'd5);
        idle();
        wr(5'd10, 32'd1);
        repeat (4) idle();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("t5_reset_irq", {31'd0, irq}, 32'd0);
        check("t5_reset_readdata", readdata, 32'd0);
        reset = 1'b0;
        rd(5'd11, 32'd0);
        rd(5'd0, 32'd0);
        rd(5'd5, 32'd0);
        rd(5'd20, 32'd4);
        idle();
        idle();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
